multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM of the multi-cycle MIPS CPU.
- Sequences each instruction through IF/ID/EX/MEM/WB and drives every datapath enable and mux select.
- Produces the 5-bit ALUConf and Sign codes consumed by the ALU, and takes the ALU Zero flag back for branch resolution.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- OpCode  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU Zero flag (valid in EX)
- PCWrite  output  1  PC load enable
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load enable
- RegWrite  output  1  register file write enable
- RegDst  output  2  write register: 00=rt, 01=rd, 10=$31
- MemtoReg  output  2  write data: 00=ALUOut, 01=MDR, 10=PC
- ExtOp  output  1  immediate extension: 1=sign, 0=zero
- LuiOp  output  1  1: extender outputs {imm,16'h0}
- ALUSrcA  output  2  ALU In1: 00=PC, 01=A reg, 10=shamt
- ALUSrcB  output  2  ALU In2: 00=B reg, 01=32'd4, 10=ext imm, 11=ext imm<<2
- ALUConf  output  5  ALU op: add 00000, or 00001, and 00010, sub 00110, slt 00111, nor 01100, xor 01101, srl 10000, sra 11000, sll 11001
- Sign  output  1  1: signed compare for slt
- PCSource  output  2  PC next: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}, 11=A reg
- State  output  3  current state (debug): IF=0, ID=1, EX=2, MEM=3, WB=4

Behaviour:
- State register: async active-low reset to IF. Outputs are decoded combinationally from State, OpCode, Funct and Zero.
- While reset=0, every output is forced to 0, with State=0 and no write enables asserted. The first rising edge after release performs a fetch.
- Default for any output not listed in a state is 0.
- IF:
  - MemRead=1, IorD=0, IRWrite=1.
  - ALUSrcA=00, ALUSrcB=01, ALUConf=add, PCSource=00, PCWrite=1.
  - Next state: ID.
- ID:
  - ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUConf=add (branch target computed into ALUOut).
  - j: PCWrite=1, PCSource=10.
  - jal: same as j, plus RegWrite=1, RegDst=10, MemtoReg=10. PC still holds PC+4 at this edge, so the link value is correct.
  - Next state: IF for j, jal and unsupported opcodes (executed as nop). EX otherwise.
- EX, R-type:
  - add/addu → add; sub/subu → sub; and, or, xor, nor → matching code.
  - slt → slt with Sign=1; sltu → slt with Sign=0.
  - ALUSrcA=01, ALUSrcB=00.
  - sll/srl/sra: ALUSrcA=10 (shift amount on In1, value on In2).
  - jr: PCWrite=1, PCSource=11.
  - jalr: PCWrite=1, PCSource=11, RegWrite=1, RegDst=01, MemtoReg=10.
  - Unsupported Funct: no writes.
- EX, I-type (ALUSrcA=01, ALUSrcB=10):
  - addi/addiu: add, ExtOp=1.
  - andi: and, ExtOp=0. ori: or, ExtOp=0.
  - slti: slt, Sign=1, ExtOp=1. sltiu: slt, Sign=0, ExtOp=1.
  - lui: LuiOp=1, add (rs=$0 by encoding).
  - lw/sw: add, ExtOp=1.
- EX, beq/bne:
  - ALUSrcA=01, ALUSrcB=00, ALUConf=sub, PCSource=01.
  - PCWrite = Zero for beq, !Zero for bne.
- EX next state: IF for beq, bne, jr, jalr and unsupported Funct; MEM for lw/sw; WB otherwise.
- MEM:
  - IorD=1, with MemRead=1 (lw) or MemWrite=1 (sw).
  - Next state: WB for lw, IF for sw.
- WB:
  - RegWrite=1.
  - lw: MemtoReg=01, RegDst=00.
  - R-type: MemtoReg=00, RegDst=01.
  - I-arith/lui: MemtoReg=00, RegDst=00.
  - Next state: IF.
- Cycle counts: j/jal 2; beq/bne/jr/jalr 3; R-type, I-arith, lui and sw 4; lw 5.
- Exclusivity: MemRead and MemWrite are never high in the same cycle. PCWrite is high at most once outside IF per instruction.
- Reset mid-instruction:
  - All outputs drop to 0 immediately (asynchronous).
  - State returns to IF; no partial write occurs after the reset edge.
  - Restart at the next fetch.

Test Plan:
- Reset held low 3 cycles, then released → outputs all 0 during reset. First cycle after release: State=0, PCWrite=IRWrite=MemRead=1, ALUConf=00000, ALUSrcB=01.
- add (OpCode 0x00, Funct 0x20) → State 0,1,2,4,0. EX: ALUConf=00000, ALUSrcA=01, ALUSrcB=00. WB: RegWrite=1, RegDst=01.
- lw (0x23) then sw (0x2B) → lw takes 5 cycles, MEM: IorD=1, MemRead=1; WB: MemtoReg=01, RegDst=00. sw takes 4 cycles, MEM: MemWrite=1, RegWrite never asserted.
- beq (0x04) with Zero=1, then bne (0x05) with Zero=1 → beq EX: PCWrite=1, PCSource=01, ALUConf=00110. bne EX: PCWrite=0. Both return to IF after 3 cycles.
- sltiu (0x0B), andi (0x0C), sra (Funct 0x03) → sltiu: ALUConf=00111, Sign=0, ExtOp=1. andi: ALUConf=00010, ExtOp=0. sra: ALUConf=11000, ALUSrcA=10.
- jal (0x03), then reset pulsed low during the EX cycle of an add → jal ID: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; 2 cycles total. Reset: outputs go to 0 asynchronously, State=0, no WB RegWrite occurs.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS CPU: steps each instruction through
// IF/ID/EX/MEM/WB and decodes every datapath enable and mux select combinationally.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ExtOp,
   output logic       LuiOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [4:0] ALUConf,
   output logic       Sign,
   output logic [1:0] PCSource,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                          OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                          OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
                          F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                          F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                          F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
   localparam logic [4:0] ALU_ADD = 5'b00000, ALU_OR = 5'b00001, ALU_AND = 5'b00010,
                          ALU_SUB = 5'b00110, ALU_SLT = 5'b00111, ALU_NOR = 5'b01100,
                          ALU_XOR = 5'b01101, ALU_SRL = 5'b10000, ALU_SRA = 5'b11000,
                          ALU_SLL = 5'b11001;

   state_t     r_state;
   state_t     w_next_state;
   logic       w_is_r, w_is_j, w_is_jal, w_is_beq, w_is_bne;
   logic       w_is_lw, w_is_sw, w_is_lui, w_is_iarith;
   logic       w_r_shift, w_r_jr, w_r_jalr, w_r_alu, w_r_sign;
   logic [4:0] w_r_conf;
   logic       w_i_sign, w_i_ext;
   logic [4:0] w_i_conf;

   assign w_is_r   = (OpCode == OP_R);
   assign w_is_j   = (OpCode == OP_J);
   assign w_is_jal = (OpCode == OP_JAL);
   assign w_is_beq = (OpCode == OP_BEQ);
   assign w_is_bne = (OpCode == OP_BNE);
   assign w_is_lw  = (OpCode == OP_LW);
   assign w_is_sw  = (OpCode == OP_SW);
   assign w_is_lui = (OpCode == OP_LUI);

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin : instr_decode
      w_r_conf  = ALU_ADD;
      w_r_sign  = 1'b0;
      w_r_shift = 1'b0;
      w_r_jr    = 1'b0;
      w_r_jalr  = 1'b0;
      w_r_alu   = 1'b1;
      case (Funct)
         F_SLL:         begin w_r_conf = ALU_SLL; w_r_shift = 1'b1; end
         F_SRL:         begin w_r_conf = ALU_SRL; w_r_shift = 1'b1; end
         F_SRA:         begin w_r_conf = ALU_SRA; w_r_shift = 1'b1; end
         F_ADD, F_ADDU: w_r_conf = ALU_ADD;
         F_SUB, F_SUBU: w_r_conf = ALU_SUB;
         F_AND:         w_r_conf = ALU_AND;
         F_OR:          w_r_conf = ALU_OR;
         F_XOR:         w_r_conf = ALU_XOR;
         F_NOR:         w_r_conf = ALU_NOR;
         F_SLT:         begin w_r_conf = ALU_SLT; w_r_sign = 1'b1; end
         F_SLTU:        w_r_conf = ALU_SLT;
         F_JR:          begin w_r_jr = 1'b1;   w_r_alu = 1'b0; end
         F_JALR:        begin w_r_jalr = 1'b1; w_r_alu = 1'b0; end
         default:       w_r_alu = 1'b0;
      endcase

      w_i_conf    = ALU_ADD;
      w_i_sign    = 1'b0;
      w_i_ext     = 1'b1;
      w_is_iarith = 1'b1;
      case (OpCode)
         OP_ADDI, OP_ADDIU: w_i_conf = ALU_ADD;
         OP_SLTI:           begin w_i_conf = ALU_SLT; w_i_sign = 1'b1; end
         OP_SLTIU:          w_i_conf = ALU_SLT;
         OP_ANDI:           begin w_i_conf = ALU_AND; w_i_ext = 1'b0; end
         OP_ORI:            begin w_i_conf = ALU_OR;  w_i_ext = 1'b0; end
         default:           w_is_iarith = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IF;
      else        r_state <= w_next_state;
   end

   always_comb begin : ctrl_decode
      PCWrite      = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      RegDst       = 2'b00;
      MemtoReg     = 2'b00;
      ExtOp        = 1'b0;
      LuiOp        = 1'b0;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUConf      = ALU_ADD;
      Sign         = 1'b0;
      PCSource     = 2'b00;
      State        = 3'd0;
      w_next_state = S_IF;
      // Reset masks the outputs asynchronously so nothing is written while it is held.
      if (reset) begin
         State = r_state;
         case (r_state)
            S_IF: begin
               MemRead      = 1'b1;
               IRWrite      = 1'b1;
               ALUSrcB      = 2'b01;
               PCWrite      = 1'b1;
               w_next_state = S_ID;
            end
            S_ID: begin
               ALUSrcB = 2'b11;
               ExtOp   = 1'b1;
               if (w_is_j || w_is_jal) begin
                  PCWrite  = 1'b1;
                  PCSource = 2'b10;
               end
               if (w_is_jal) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b10;
                  MemtoReg = 2'b10;
               end
               if (w_is_r || w_is_beq || w_is_bne || w_is_lw || w_is_sw || w_is_lui || w_is_iarith)
                  w_next_state = S_EX;
            end
            S_EX: begin
               if (w_is_r) begin
                  ALUSrcA = w_r_shift ? 2'b10 : 2'b01;
                  ALUConf = w_r_conf;
                  Sign    = w_r_sign;
                  if (w_r_jr || w_r_jalr) begin
                     PCWrite  = 1'b1;
                     PCSource = 2'b11;
                  end
                  if (w_r_jalr) begin
                     RegWrite = 1'b1;
                     RegDst   = 2'b01;
                     MemtoReg = 2'b10;
                  end
                  w_next_state = w_r_alu ? S_WB : S_IF;
               end else if (w_is_beq || w_is_bne) begin
                  ALUSrcA  = 2'b01;
                  ALUConf  = ALU_SUB;
                  PCSource = 2'b01;
                  PCWrite  = w_is_beq ? Zero : !Zero;
               end else begin
                  ALUSrcA      = 2'b01;
                  ALUSrcB      = 2'b10;
                  ALUConf      = w_i_conf;
                  Sign         = w_i_sign;
                  ExtOp        = w_is_lui ? 1'b0 : w_i_ext;
                  LuiOp        = w_is_lui;
                  w_next_state = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
               end
            end
            S_MEM: begin
               IorD         = 1'b1;
               MemRead      = w_is_lw;
               MemWrite     = w_is_sw;
               w_next_state = w_is_lw ? S_WB : S_IF;
            end
            S_WB: begin
               RegWrite = 1'b1;
               if (w_is_lw)     MemtoReg = 2'b01;
               else if (w_is_r) RegDst   = 2'b01;
            end
            default: w_next_state = S_IF;
         endcase
      end
   end

endmodule
